mem_port_arbiter: RTL

// - Shares the central memory data ports (ROM/RAM read port rdaddress_D/q_D, RAM write port) between two requesters:
//   R0 = CPU load/store stage, R1 = DMA/image engine.
// - Issues at most one access per cycle, round-robin between requesters.
// - Tracks read latency with a tag pipeline and returns read data to the requester that issued the read.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the central memory read/write data ports between the CPU (R0) and DMA (R1) requesters.
// Build option: define MEM_ARB_CPU_PRIORITY_EN for fixed R0 priority instead of round-robin.
module mem_port_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned READ_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_rdaddress,
    output logic             mem_r_ena,
    output logic [WIDTH-1:0] mem_wraddress,
    output logic             mem_wr_ena,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_q
);

    localparam int unsigned LAST = READ_LAT - 1;

    logic             issue;
    logic             issue_id;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;

    // Read tags: valid bit plus requester id, one stage per clock
    logic tag_vld [READ_LAT];
    logic tag_id  [READ_LAT];

`ifdef MEM_ARB_CPU_PRIORITY_EN
    // R0 wins every tie; R1 only gets the port when R0 is idle
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = req0;
            gnt1 = req1 && !req0;
        end
    end
`else
    typedef enum logic {
        PTR_R0 = 1'b0,
        PTR_R1 = 1'b1
    } rr_ptr_t;

    rr_ptr_t rr_ptr;
    rr_ptr_t rr_ptr_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= PTR_R0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Pointer only moves when a tie is resolved in its favour
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rr_ptr_next = rr_ptr;
        if (!reset) begin
            if (req0 && req1) begin
                if (rr_ptr == PTR_R0) begin
                    gnt0        = 1'b1;
                    rr_ptr_next = PTR_R1;
                end else begin
                    gnt1        = 1'b1;
                    rr_ptr_next = PTR_R0;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end
`endif

    always_comb begin
        issue     = gnt0 || gnt1;
        issue_id  = gnt1;
        sel_we    = gnt1 ? we1 : we0;
        sel_addr  = gnt1 ? addr1 : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
    end

    // Memory port issue, tag pipeline and read-return pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_rdaddress <= '0;
            mem_wraddress <= '0;
            mem_data_in   <= '0;
            mem_r_ena     <= 1'b0;
            mem_wr_ena    <= 1'b0;
            rvalid0       <= 1'b0;
            rvalid1       <= 1'b0;
            for (int unsigned k = 0; k < READ_LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= 1'b0;
            end
        end else begin
            mem_r_ena  <= 1'b0;
            mem_wr_ena <= 1'b0;
            if (issue) begin
                if (sel_we) begin
                    mem_wraddress <= sel_addr;
                    mem_data_in   <= sel_wdata;
                    mem_wr_ena    <= 1'b1;
                end else begin
                    mem_rdaddress <= sel_addr;
                    mem_r_ena     <= 1'b1;
                end
            end
            tag_vld[0] <= issue && !sel_we;
            tag_id[0]  <= issue_id;
            for (int unsigned k = 1; k < READ_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            rvalid0 <= tag_vld[LAST] && !tag_id[LAST];
            rvalid1 <= tag_vld[LAST] && tag_id[LAST];
        end
    end

    // Memory output is forwarded only during the return pulse
    always_comb begin
        rdata = '0;
        if (rvalid0 || rvalid1) begin
            rdata = mem_q;
        end
    end

endmodule
